// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the unified memory.
// The arbiter uses the slave view; the requesters and memory model use master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_done;
    logic [DATA_W-1:0] c_rdata;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_done;
    logic [DATA_W-1:0] l_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  mem_rdata,
        output c_done, c_rdata, l_done, l_rdata,
        output mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output mem_rdata,
        input  c_done, c_rdata, l_done, l_rdata,
        input  mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the unified memory shared by the core and loader.
// Serialises accesses, waits MEM_LAT cycles, then pulses the owner's done.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              own_q, own_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              c_done_q, c_done_d;
    logic              l_done_q, l_done_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
    logic              busy_q, busy_d;
    logic              pick;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        own_d     = own_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_we_d  = 1'b0;
        c_done_d  = 1'b0;
        l_done_d  = 1'b0;
        c_rdata_d = c_rdata_q;
        l_rdata_d = l_rdata_q;
        pick      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.c_req || bus.l_req) begin
                    // pick: 0 = core, 1 = loader; pointer only moves on a tie
                    if (bus.c_req && bus.l_req) begin
                        pick   = prio_q;
                        prio_d = ~prio_q;
                    end else begin
                        pick = bus.l_req;
                    end
                    own_d    = pick;
                    we_d     = pick ? bus.l_we    : bus.c_we;
                    addr_d   = pick ? bus.l_addr  : bus.c_addr;
                    wdata_d  = pick ? bus.l_wdata : bus.c_wdata;
                    mem_we_d = we_d;
                    cnt_d    = LAT;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (own_q) l_rdata_d = bus.mem_rdata;
                        else       c_rdata_d = bus.mem_rdata;
                    end
                    c_done_d = ~own_q;
                    l_done_d = own_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            prio_q    <= 1'b0;
            own_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_we_q  <= 1'b0;
            c_done_q  <= 1'b0;
            l_done_q  <= 1'b0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            own_q     <= own_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_we_q  <= mem_we_d;
            c_done_q  <= c_done_d;
            l_done_q  <= l_done_d;
            c_rdata_q <= c_rdata_d;
            l_rdata_q <= l_rdata_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.c_done    = c_done_q;
    assign bus.l_done    = l_done_q;
    assign bus.c_rdata   = c_rdata_q;
    assign bus.l_rdata   = l_rdata_q;
    assign bus.busy      = busy_q;
endmodule
